// File: rtl/mem_stage.sv
// Memory pipeline stage: EX/MEM and MEM/WB registers around a word-addressed data memory.
// Optional EX/MEM bypass outputs are enabled by defining MEM_STAGE_FWD_EN.
module mem_stage #(
    parameter int unsigned DMEM_WORDS = 256,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_regwr,
    input  logic        ex_mem2reg,
    input  logic        ex_memwr,
    input  logic        ex_signext,
    input  logic [1:0]  ex_size,
    input  logic [4:0]  ex_rw,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_storedata,
    input  logic        stall,
    input  logic        flush,
    output logic        mem2reg,
    output logic        regwrin,
    output logic [4:0]  rwin,
    output logic [31:0] execresult,
    output logic [31:0] dmem,
    output logic        misalign_err,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rw,
    output logic [31:0] fwd_data
);

    // EX/MEM register
    logic        em_regwr_q;
    logic        em_mem2reg_q;
    logic        em_memwr_q;
    logic        em_signext_q;
    logic [1:0]  em_size_q;
    logic [4:0]  em_rw_q;
    logic [31:0] em_result_q;
    logic [31:0] em_storedata_q;

    // MEM/WB register
    logic        wb_mem2reg_q;
    logic        wb_regwr_q;
    logic [4:0]  wb_rw_q;
    logic [31:0] wb_result_q;
    logic [31:0] wb_dmem_q;
    logic        err_q;

    logic [31:0] mem [DMEM_WORDS];

    logic [ADDR_W-1:0] idx;
    logic [31:0]       rdata;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_ext;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic              access;
    logic              misalign;
    logic              mem_we;
    logic [31:0]       dmem_d;
    logic              regwr_d;

    assign idx    = em_result_q[ADDR_W+1:2];
    assign rdata  = mem[idx];
    assign access = em_mem2reg_q | em_memwr_q;

    always_comb begin
        misalign = 1'b0;
        if (access) begin
            if (em_size_q == 2'b01) begin
                misalign = em_result_q[0];
            end else if (em_size_q[1]) begin
                misalign = (em_result_q[1:0] != 2'b00);
            end
        end
    end

    always_comb begin
        byte_sel = rdata[7:0];
        case (em_result_q[1:0])
            2'b00:   byte_sel = rdata[7:0];
            2'b01:   byte_sel = rdata[15:8];
            2'b10:   byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = em_result_q[1] ? rdata[31:16] : rdata[15:0];
        case (em_size_q)
            2'b00: begin
                load_ext = em_signext_q ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
            end
            2'b01: begin
                load_ext = em_signext_q ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
            end
            default: load_ext = rdata;
        endcase
    end

    // Narrow stores replicate the data across lanes; byte enables pick the lane.
    always_comb begin
        case (em_size_q)
            2'b00: begin
                wdata = {4{em_storedata_q[7:0]}};
                be    = 4'b0001 << em_result_q[1:0];
            end
            2'b01: begin
                wdata = {2{em_storedata_q[15:0]}};
                be    = em_result_q[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata = em_storedata_q;
                be    = 4'b1111;
            end
        endcase
    end

    assign mem_we  = em_memwr_q & ~stall & ~misalign;
    assign dmem_d  = misalign ? 32'h0 : load_ext;
    assign regwr_d = em_regwr_q & (em_rw_q != 5'd0) & ~(misalign & em_mem2reg_q);

    // Memory is not reset; an async reset clears em_memwr_q, which blocks a pending write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            em_regwr_q     <= 1'b0;
            em_mem2reg_q   <= 1'b0;
            em_memwr_q     <= 1'b0;
            em_signext_q   <= 1'b0;
            em_size_q      <= 2'b00;
            em_rw_q        <= 5'd0;
            em_result_q    <= 32'h0;
            em_storedata_q <= 32'h0;
            wb_mem2reg_q   <= 1'b0;
            wb_regwr_q     <= 1'b0;
            wb_rw_q        <= 5'd0;
            wb_result_q    <= 32'h0;
            wb_dmem_q      <= 32'h0;
            err_q          <= 1'b0;
        end else begin
            // Flush wins over stall for EX/MEM only.
            if (flush) begin
                em_regwr_q     <= 1'b0;
                em_mem2reg_q   <= 1'b0;
                em_memwr_q     <= 1'b0;
                em_signext_q   <= 1'b0;
                em_size_q      <= 2'b00;
                em_rw_q        <= 5'd0;
                em_result_q    <= 32'h0;
                em_storedata_q <= 32'h0;
            end else if (!stall) begin
                em_regwr_q     <= ex_regwr;
                em_mem2reg_q   <= ex_mem2reg;
                em_memwr_q     <= ex_memwr;
                em_signext_q   <= ex_signext;
                em_size_q      <= ex_size;
                em_rw_q        <= ex_rw;
                em_result_q    <= ex_result;
                em_storedata_q <= ex_storedata;
            end
            if (!stall) begin
                wb_mem2reg_q <= em_mem2reg_q;
                wb_regwr_q   <= regwr_d;
                wb_rw_q      <= em_rw_q;
                wb_result_q  <= em_result_q;
                wb_dmem_q    <= dmem_d;
                if (misalign) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign mem2reg      = wb_mem2reg_q;
    assign regwrin      = wb_regwr_q;
    assign rwin         = wb_rw_q;
    assign execresult   = wb_result_q;
    assign dmem         = wb_dmem_q;
    assign misalign_err = err_q;

`ifdef MEM_STAGE_FWD_EN
    assign fwd_valid = em_regwr_q & ~em_mem2reg_q & (em_rw_q != 5'd0);
    assign fwd_rw    = em_rw_q;
    assign fwd_data  = em_result_q;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rw    = 5'd0;
    assign fwd_data  = 32'h0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: byte-array reference model plus directed vectors.
module tb_mem_stage;

    localparam int unsigned WORDS = 256;
    localparam int unsigned BYTES = WORDS * 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ex_regwr, ex_mem2reg, ex_memwr, ex_signext;
    logic [1:0]  ex_size;
    logic [4:0]  ex_rw;
    logic [31:0] ex_result, ex_storedata;
    logic        stall, flush;
    logic        mem2reg, regwrin, misalign_err, fwd_valid;
    logic [4:0]  rwin, fwd_rw;
    logic [31:0] execresult, dmem, fwd_data;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    mem_stage #(.DMEM_WORDS(WORDS), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_regwr(ex_regwr), .ex_mem2reg(ex_mem2reg), .ex_memwr(ex_memwr),
        .ex_signext(ex_signext), .ex_size(ex_size), .ex_rw(ex_rw),
        .ex_result(ex_result), .ex_storedata(ex_storedata),
        .stall(stall), .flush(flush),
        .mem2reg(mem2reg), .regwrin(regwrin), .rwin(rwin), .execresult(execresult),
        .dmem(dmem), .misalign_err(misalign_err),
        .fwd_valid(fwd_valid), .fwd_rw(fwd_rw), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        regwr;
        logic        mem2reg;
        logic        memwr;
        logic        signext;
        logic [1:0]  size;
        logic [4:0]  rw;
        logic [31:0] result;
        logic [31:0] sd;
    } op_t;

    // Reference model state: the op waiting in the stage, the visible outputs, a byte memory.
    op_t         m_em;
    logic        e_m2r, e_rwe, e_err;
    logic [4:0]  e_rw;
    logic [31:0] e_exec, e_dmem;
    logic [7:0]  mb [BYTES];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned nbytes(input logic [1:0] s);
        if (s == 2'b00) return 1;
        if (s == 2'b01) return 2;
        return 4;
    endfunction

    initial begin : model
        int unsigned a, n;
        logic        mis;
        logic [31:0] v;
        for (int i = 0; i < BYTES; i++) mb[i] = 8'h0;
        m_em = '0;
        {e_m2r, e_rwe, e_err, e_rw, e_exec, e_dmem} = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_em = '0;
                {e_m2r, e_rwe, e_err, e_rw, e_exec, e_dmem} = '0;
            end else begin
                if (!stall) begin
                    a   = m_em.result % BYTES;
                    n   = nbytes(m_em.size);
                    mis = (m_em.mem2reg || m_em.memwr) && (a % n != 0);
                    v   = 32'h0;
                    if (!mis) begin
                        for (int j = 0; j < int'(n); j++)
                            v = v | (32'(mb[(a + j) % BYTES]) << (8 * j));
                        if (m_em.signext && n < 4 && v[8*n-1])
                            v = v | ~((32'd1 << (8 * n)) - 32'd1);
                        if (m_em.memwr)
                            for (int j = 0; j < int'(n); j++)
                                mb[(a + j) % BYTES] = 8'(m_em.sd >> (8 * j));
                    end
                    e_m2r  = m_em.mem2reg;
                    e_rwe  = m_em.regwr && m_em.rw != 5'd0 && !(mis && m_em.mem2reg);
                    e_rw   = m_em.rw;
                    e_exec = m_em.result;
                    e_dmem = v;
                    e_err  = e_err | mis;
                end
                if (flush) m_em = '0;
                else if (!stall)
                    m_em = {ex_regwr, ex_mem2reg, ex_memwr, ex_signext, ex_size, ex_rw,
                            ex_result, ex_storedata};
            end
        end
    end

    initial begin : compare
        logic        fv;
        logic [4:0]  frw;
        logic [31:0] fd;
        forever begin
            @(negedge clk);
            if (chk_en) begin
`ifdef MEM_STAGE_FWD_EN
                fv  = m_em.regwr && !m_em.mem2reg && m_em.rw != 5'd0;
                frw = m_em.rw;
                fd  = m_em.result;
`else
                fv  = 1'b0;
                frw = 5'd0;
                fd  = 32'h0;
`endif
                check("mem2reg", 32'(mem2reg), 32'(e_m2r));
                check("regwrin", 32'(regwrin), 32'(e_rwe));
                check("rwin", 32'(rwin), 32'(e_rw));
                check("execresult", execresult, e_exec);
                check("misalign_err", 32'(misalign_err), 32'(e_err));
                if (e_m2r) check("dmem", dmem, e_dmem);
                check("fwd_valid", 32'(fwd_valid), 32'(fv));
                check("fwd_rw", 32'(fwd_rw), 32'(frw));
                check("fwd_data", fwd_data, fd);
            end
        end
    end

    task automatic drive(input logic rwe, input logic m2r, input logic mw, input logic se,
                         input logic [1:0] sz, input logic [4:0] rd, input logic [31:0] res,
                         input logic [31:0] sd, input logic st, input logic fl);
        ex_regwr = rwe; ex_mem2reg = m2r; ex_memwr = mw; ex_signext = se;
        ex_size = sz; ex_rw = rd; ex_result = res; ex_storedata = sd;
        stall = st; flush = fl;
        @(negedge clk);
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 2'b10, 5'd0, 32'h0, 32'h0, 0, 0);
    endtask

    task automatic sw(input logic [31:0] addr, input logic [31:0] d, input logic [1:0] sz);
        drive(0, 0, 1, 0, sz, 5'd0, addr, d, 0, 0);
    endtask

    task automatic ld(input logic [31:0] addr, input logic [4:0] rd, input logic [1:0] sz,
                      input logic se);
        drive(1, 1, 0, se, sz, rd, addr, 32'h0, 0, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        {ex_regwr, ex_mem2reg, ex_memwr, ex_signext} = '0;
        ex_size = 2'b00; ex_rw = 5'd0; ex_result = 32'h0; ex_storedata = 32'h0;
        stall = 1'b0; flush = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        check("reset dmem", dmem, 32'h0);
        check("reset err", 32'(misalign_err), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // word store then load
        sw(32'h10, 32'hDEADBEEF, 2'b10);
        ld(32'h10, 5'd2, 2'b10, 0);
        nop();
        check("lw dmem", dmem, 32'hDEADBEEF);
        check("lw rwin", 32'(rwin), 32'd2);
        check("lw regwrin", 32'(regwrin), 32'd1);
        check("lw mem2reg", 32'(mem2reg), 32'd1);

        // byte store then back-to-back loads of the same word
        sw(32'h13, 32'h80, 2'b00);
        ld(32'h13, 5'd3, 2'b00, 1);
        ld(32'h13, 5'd4, 2'b00, 0);
        check("lb signed", dmem, 32'hFFFFFF80);
        ld(32'h10, 5'd5, 2'b10, 0);
        check("lb unsigned", dmem, 32'h00000080);
        nop();
        check("lw merged", dmem, 32'h80ADBEEF);

        // half store on upper lane
        sw(32'h16, 32'h12348001, 2'b01);
        ld(32'h16, 5'd6, 2'b01, 1);
        ld(32'h16, 5'd6, 2'b01, 0);
        check("lh signed", dmem, 32'hFFFF8001);
        nop();
        check("lh unsigned", dmem, 32'h00008001);

        // ALU op forwarding and register-0 suppression
        drive(1, 0, 0, 0, 2'b10, 5'd5, 32'd42, 32'h0, 0, 0);
`ifdef MEM_STAGE_FWD_EN
        check("fwd_valid alu", 32'(fwd_valid), 32'd1);
        check("fwd_rw alu", 32'(fwd_rw), 32'd5);
        check("fwd_data alu", fwd_data, 32'd42);
`else
        check("fwd_valid off", 32'(fwd_valid), 32'd0);
        check("fwd_data off", fwd_data, 32'd0);
`endif
        drive(1, 0, 0, 0, 2'b10, 5'd0, 32'd9, 32'h0, 0, 0);
        nop();
        check("r0 regwrin", 32'(regwrin), 32'd0);

        // address wrap
        sw(32'h400, 32'hCAFEF00D, 2'b10);
        ld(32'h0, 5'd7, 2'b10, 0);
        nop();
        check("wrap dmem", dmem, 32'hCAFEF00D);

        // stall three cycles, then flush the captured store
        sw(32'h20, 32'h11111111, 2'b10);
        drive(1, 0, 0, 0, 2'b10, 5'd9, 32'h99, 32'h0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 2'b10, 5'd0, 32'h20, 32'h22222222, 1, 0);
            check("stall hold", execresult, 32'h20);
        end
        drive(0, 0, 1, 0, 2'b10, 5'd0, 32'h20, 32'h22222222, 0, 1);
        check("after flush exec", execresult, 32'h99);
        drive(0, 0, 1, 0, 2'b10, 5'd0, 32'h20, 32'h33333333, 1, 1);
        ld(32'h20, 5'd10, 2'b10, 0);
        nop();
        check("flushed store", dmem, 32'h11111111);

        // misaligned accesses and sticky flag
        ld(32'h12, 5'd3, 2'b10, 0);
        nop();
        check("mis err", 32'(misalign_err), 32'd1);
        check("mis dmem", dmem, 32'h0);
        check("mis regwrin", 32'(regwrin), 32'd0);
        sw(32'h21, 32'hFFFF, 2'b01);
        ld(32'h20, 5'd4, 2'b10, 0);
        nop();
        check("mis store blocked", dmem, 32'h11111111);
        check("err sticky", 32'(misalign_err), 32'd1);

        // reset while a store waits in the stage
        sw(32'h40, 32'h55555555, 2'b10);
        nop();
        sw(32'h40, 32'hAAAAAAAA, 2'b10);
        #1 rst_n = 1'b0;
        #1;
        check("rst exec", execresult, 32'h0);
        check("rst err", 32'(misalign_err), 32'h0);
        check("rst regwrin", 32'(regwrin), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ld(32'h40, 5'd11, 2'b10, 0);
        nop();
        check("rst store blocked", dmem, 32'h55555555);
        check("post rst rwin", 32'(rwin), 32'd11);
        check("post rst err", 32'(misalign_err), 32'h0);
        nop();
        nop();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: DMEM_WORDS, 256, data memory depth in 32-bit words (power of two).
REQ-002 Parameter: ADDR_W, 8, word-index width, equal to log2(DMEM_WORDS).
REQ-003 clk  in  1  pipeline clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 Control inputs, each `in 1` from the EX stage: ex_regwr (register write), ex_mem2reg (load), ex_memwr (store), ex_signext (sign-extend loads).
REQ-006 ex_size  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-007 Data inputs: ex_rw (in 5, destination register), ex_result (in 32, ALU result and byte address), ex_storedata (in 32, store data).
REQ-008 Hazard inputs, each `in 1`: stall (hold the pipeline), flush (squash the EX/MEM entry).
REQ-009 Outputs to the Write stage: mem2reg (out 1), regwrin (out 1), rwin (out 5), execresult (out 32), dmem (out 32).
REQ-010 misalign_err  out  1  sticky misaligned-access flag.
REQ-011 Forwarding outputs: fwd_valid (out 1), fwd_rw (out 5), fwd_data (out 32); these are the EX/MEM bypass.

Function
REQ-012 The block shall contain two registers: EX/MEM (captures ex_* inputs) and MEM/WB (drives the Write-stage outputs).
REQ-013 Latency shall be exactly 2 rising edges from ex_* input to output when stall=0.
REQ-014 The data memory shall be DMEM_WORDS x 32 and indexed by EX/MEM result[ADDR_W+1:2]; upper address bits are ignored, so addresses wrap modulo the memory size.
REQ-015 The memory read shall be combinational from the EX/MEM address; load data is captured into dmem at the next edge.
REQ-016 Load byte lane: selected by addr[1:0]. Load half lane: selected by addr[1]. The extracted value shall be sign-extended if signext=1, else zero-extended.
REQ-017 A store shall write on the edge that advances EX/MEM to MEM/WB.
  - Byte and half stores update only the addressed lane(s); all other bytes are preserved.
REQ-018 Misaligned access is a half access with addr[0]=1, or a word access with addr[1:0]!=0. On a misaligned access:
  - no memory write occurs;
  - dmem captures 0;
  - regwrin is forced to 0 for a misaligned load;
  - misalign_err is set to 1 and holds until reset.
REQ-019 execresult shall equal the EX/MEM result; mem2reg, regwrin and rwin follow EX/MEM, subject to REQ-018.
REQ-020 stall=1 shall hold both registers unchanged and suppress any store write.
REQ-021 flush=1 shall load a bubble into EX/MEM (regwr=0, memwr=0, mem2reg=0, rw=0, data=0).
  - flush has priority over stall for EX/MEM; MEM/WB still holds under stall.
  - A store squashed by flush shall never write memory.
REQ-022 regwrin shall be 0 whenever rwin=0; register 0 is never written.
REQ-023 A store followed by a load of the same word in the next cycle shall return the newly stored data.

Reset
REQ-024 rst_n=0 shall immediately clear both registers and misalign_err.
  - All outputs read 0 while reset is asserted.
  - Memory contents are unaffected.
REQ-025 Asserting reset mid-store (before the edge) shall prevent that write.
REQ-026 The first edge after rst_n rises shall capture ex_* normally.

Configuration
REQ-027 Macro MEM_STAGE_FWD_EN.
  - Defined: fwd_valid = EX/MEM regwr & ~mem2reg & (rw!=0); fwd_rw = EX/MEM rw; fwd_data = EX/MEM result.
  - Undefined: the fwd_* ports remain present and are driven constant 0.
  - The macro has no other effect.

Verification
REQ-028 Word store of 0xDEADBEEF to addr 0x10, then word load of 0x10 with rw=2 -> two edges later dmem=0xDEADBEEF, rwin=2, regwrin=1, mem2reg=1.
REQ-029 Byte store of 0x80 to addr 0x13, then signed byte load and unsigned byte load of 0x13 -> dmem=0xFFFFFF80, then 0x00000080; word load of 0x10 -> 0x80ADBEEF.
REQ-030 Word load of addr 0x12 -> misalign_err=1, dmem=0, regwrin=0; the flag stays 1 across later aligned accesses until rst_n=0.
REQ-031 Store to 0x20 presented with stall=1 for 3 cycles and flush=1 on the capture edge -> memory word 8 unchanged; outputs held during stall.
REQ-032 ALU op with regwr=1, rw=5, result=42 -> with MEM_STAGE_FWD_EN: fwd_valid=1, fwd_rw=5, fwd_data=42 one edge after issue; without the macro: all fwd_* = 0.
REQ-033 Address 0x400 with DMEM_WORDS=256 -> accesses word 0 (wrap).
